// File: rtl/regfile_mp_pkg.sv
// rtl/regfile_mp_pkg.sv - shared state type, default sizes and write-port priority helper for regfile_mp
package regfile_mp_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_DEPTH      = 32;
  localparam int RF_NUM_RD     = 2;
  localparam int RF_NUM_WR     = 2;
  localparam int RF_MAX_WR     = 8;

  // Highest set index wins; callers gate on any hit, so 0 for an empty vector is harmless.
  function automatic int rf_win_port(input logic [RF_MAX_WR-1:0] hits);
    int win;
    win = 0;
    for (int j = 0; j < RF_MAX_WR; j++) begin
      if (hits[j]) win = j;
    end
    return win;
  endfunction

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// rtl/regfile_mp_scoreboard.sv - per-register busy bits with set-over-clear priority and x0 masking
module regfile_mp_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DEPTH      = RF_DEPTH,
  parameter int NUM_RD     = RF_NUM_RD,
  parameter int NUM_WR     = RF_NUM_WR
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         ready_i,
  input  logic                         set_en_i,
  input  logic [ADDR_WIDTH-1:0]        set_addr_i,
  input  logic [NUM_WR-1:0]            clr_en_i,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] clr_addr_i,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rs_addr_i,
  output logic [NUM_RD-1:0]            rs_busy_o
);

  logic [DEPTH-1:0]      busy_q, busy_d;
  logic                  set_hit, clr_hit;
  logic [ADDR_WIDTH-1:0] ra;

  always_comb begin
    busy_d  = busy_q;
    set_hit = 1'b0;
    clr_hit = 1'b0;
    busy_d[0] = 1'b0;
    for (int e = 1; e < DEPTH; e++) begin
      set_hit = ready_i && set_en_i && (set_addr_i == ADDR_WIDTH'(e));
      clr_hit = 1'b0;
      for (int j = 0; j < NUM_WR; j++) begin
        if (ready_i && clr_en_i[j] && (clr_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(e)))
          clr_hit = 1'b1;
      end
      // A same-cycle set means a new producer was issued, so it overrides the retiring clear.
      busy_d[e] = set_hit | (busy_q[e] & ~clr_hit);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  always_comb begin
    rs_busy_o = '0;
    ra        = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = rs_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      for (int e = 1; e < DEPTH; e++) begin
        if (ra == ADDR_WIDTH'(e)) rs_busy_o[k] = busy_q[e] & ready_i;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with post-reset clear sweep and busy scoreboard
// Optional same-cycle write-to-read bypass when REGFILE_MP_BYPASS_EN is defined.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DEPTH      = RF_DEPTH,
  parameter int NUM_RD     = RF_NUM_RD,
  parameter int NUM_WR     = RF_NUM_WR
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rs_addr_i,
  output logic [NUM_RD*DATA_WIDTH-1:0] rs_data_o,
  output logic [NUM_RD-1:0]            rs_busy_o,
  input  logic [NUM_WR-1:0]            rd_wr_en_i,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] rd_addr_i,
  input  logic [NUM_WR*DATA_WIDTH-1:0] rd_wr_data_i,
  input  logic [NUM_WR-1:0]            rd_clr_busy_i,
  input  logic                         busy_set_en_i,
  input  logic [ADDR_WIDTH-1:0]        busy_set_addr_i,
  output logic                         ready_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  rf_state_e             state_q;
  logic [ADDR_WIDTH-1:0] clr_ptr_q;
  logic                  ready_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [DEPTH-1:0]      wr_en_d;
  logic [DATA_WIDTH-1:0] wr_data_d [DEPTH];
  logic [RF_MAX_WR-1:0]  hits;
  logic [ADDR_WIDTH-1:0] ra;
  logic [DATA_WIDTH-1:0] rdata;
  logic [NUM_RD-1:0]     byp_clr;
  logic [NUM_RD-1:0]     sb_busy;
`ifdef REGFILE_MP_BYPASS_EN
  logic [DEPTH-1:0]      wr_clr_d;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= RF_CLEAR;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
    end else if (state_q == RF_CLEAR) begin
      clr_ptr_q <= clr_ptr_q + ADDR_WIDTH'(1);
      if (clr_ptr_q == LAST_IDX) begin
        state_q   <= RF_READY;
        ready_q   <= 1'b1;
        clr_ptr_q <= '0;
      end
    end
  end

  assign ready_o = ready_q;

  // Per-entry write arbitration; entry 0 and addresses at or beyond DEPTH never match.
  always_comb begin
    wr_en_d = '0;
    hits    = '0;
`ifdef REGFILE_MP_BYPASS_EN
    wr_clr_d = '0;
`endif
    for (int e = 0; e < DEPTH; e++) wr_data_d[e] = '0;
    for (int e = 1; e < DEPTH; e++) begin
      hits = '0;
      for (int j = 0; j < NUM_WR; j++) begin
        hits[j] = rd_wr_en_i[j] && (rd_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(e));
      end
      if ((state_q == RF_READY) && (|hits)) begin
        wr_en_d[e]   = 1'b1;
        wr_data_d[e] = rd_wr_data_i[rf_win_port(hits)*DATA_WIDTH +: DATA_WIDTH];
`ifdef REGFILE_MP_BYPASS_EN
        wr_clr_d[e]  = rd_clr_busy_i[rf_win_port(hits)];
`endif
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (state_q == RF_CLEAR) begin
          if (clr_ptr_q == ADDR_WIDTH'(e)) mem_q[e] <= '0;
        end else if (wr_en_d[e]) begin
          mem_q[e] <= wr_data_d[e];
        end
      end
    end
  end

  always_comb begin
    rs_data_o = '0;
    byp_clr   = '0;
    ra        = '0;
    rdata     = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra    = rs_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      rdata = '0;
      if (state_q == RF_READY) begin
        for (int e = 1; e < DEPTH; e++) begin
          if (ra == ADDR_WIDTH'(e)) rdata = mem_q[e];
        end
`ifdef REGFILE_MP_BYPASS_EN
        for (int e = 1; e < DEPTH; e++) begin
          if ((ra == ADDR_WIDTH'(e)) && wr_en_d[e]) begin
            rdata      = wr_data_d[e];
            byp_clr[k] = wr_clr_d[e];
          end
        end
`endif
      end
      rs_data_o[k*DATA_WIDTH +: DATA_WIDTH] = rdata;
    end
  end

  regfile_mp_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH),
    .NUM_RD    (NUM_RD),
    .NUM_WR    (NUM_WR)
  ) u_scoreboard (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .ready_i   (state_q == RF_READY),
    .set_en_i  (busy_set_en_i),
    .set_addr_i(busy_set_addr_i),
    .clr_en_i  (rd_wr_en_i & rd_clr_busy_i),
    .clr_addr_i(rd_addr_i),
    .rs_addr_i (rs_addr_i),
    .rs_busy_o (sb_busy)
  );

  assign rs_busy_o = sb_busy & ~byp_clr;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp (DEPTH 32 and DEPTH 16 instances)
module tb_regfile_mp;

  logic        clk;
  logic        reset;
  logic [9:0]  rs_addr;
  logic [63:0] rs_data;
  logic [1:0]  rs_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [1:0]  wr_clr;
  logic        bset_en;
  logic [4:0]  bset_addr;
  logic        ready;

  logic [9:0]  b_rs_addr;
  logic [63:0] b_rs_data;
  logic [1:0]  b_rs_busy;
  logic [1:0]  b_wr_en;
  logic [9:0]  b_wr_addr;
  logic [63:0] b_wr_data;
  logic [1:0]  b_wr_clr;
  logic        b_bset_en;
  logic [4:0]  b_bset_addr;
  logic        b_ready;

  int nvec  = 0;
  int nfail = 0;
  int first_a;
  int first_b;

`ifdef REGFILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_mp u_dut (
    .clk_i(clk), .reset_i(reset), .rs_addr_i(rs_addr), .rs_data_o(rs_data), .rs_busy_o(rs_busy),
    .rd_wr_en_i(wr_en), .rd_addr_i(wr_addr), .rd_wr_data_i(wr_data), .rd_clr_busy_i(wr_clr),
    .busy_set_en_i(bset_en), .busy_set_addr_i(bset_addr), .ready_o(ready)
  );

  regfile_mp #(.DEPTH(16), .ADDR_WIDTH(5)) u_dut16 (
    .clk_i(clk), .reset_i(reset), .rs_addr_i(b_rs_addr), .rs_data_o(b_rs_data), .rs_busy_o(b_rs_busy),
    .rd_wr_en_i(b_wr_en), .rd_addr_i(b_wr_addr), .rd_wr_data_i(b_wr_data), .rd_clr_busy_i(b_wr_clr),
    .busy_set_en_i(b_bset_en), .busy_set_addr_i(b_bset_addr), .ready_o(b_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    wr_en = '0; wr_addr = '0; wr_data = '0; wr_clr = '0; bset_en = 1'b0; bset_addr = '0;
    b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0; b_wr_clr = '0; b_bset_en = 1'b0; b_bset_addr = '0;
  endtask

  task automatic drv_wr(input int j, input logic [4:0] a, input logic [31:0] d, input logic c);
    wr_en[j] = 1'b1; wr_addr[j*5 +: 5] = a; wr_data[j*32 +: 32] = d; wr_clr[j] = c;
  endtask

  task automatic drv_rd(input logic [4:0] a0, input logic [4:0] a1);
    rs_addr = {a1, a0};
  endtask

  task automatic wait_ready(output int na, output int nb);
    na = 0;
    nb = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (ready && na == 0) na = n;
      if (b_ready && nb == 0) nb = n;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clr_in();
    drv_rd(5'd2, 5'd31);
    b_rs_addr = '0;
    tick();
    tick();
    #1;
    nvec++;
    if ({ready, b_ready, rs_data, rs_busy} !== '0) begin
      nfail++;
      $display("FAIL reset_state ready=%b rdy16=%b data=%h busy=%b want all 0", ready, b_ready, rs_data, rs_busy);
    end
    reset = 1'b0;
    first_a = 0;
    first_b = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n == 5) begin
        drv_wr(0, 5'd2, 32'h0000_0055, 1'b0);
        bset_en = 1'b1; bset_addr = 5'd2;
        #1;
        nvec++;
        if ({rs_data, rs_busy} !== '0) begin
          nfail++;
          $display("FAIL clear_reads data=%h busy=%b want 0", rs_data, rs_busy);
        end
      end
      if (n == 6) clr_in();
      if (ready && first_a == 0) first_a = n;
      if (b_ready && first_b == 0) first_b = n;
    end
    nvec++;
    if (first_a != 32) begin
      nfail++;
      $display("FAIL ready_latency got %0d want 32", first_a);
    end
    nvec++;
    if (first_b != 16) begin
      nfail++;
      $display("FAIL ready_latency16 got %0d want 16", first_b);
    end
    drv_rd(5'd2, 5'd2);
    #1;
    nvec++;
    if ({rs_data, rs_busy} !== '0) begin
      nfail++;
      $display("FAIL clear_write_dropped data=%h busy=%b want 0", rs_data, rs_busy);
    end
    for (int a = 0; a < 32; a++) begin
      drv_rd(5'(a), 5'(31 - a));
      #1;
      nvec++;
      if ({rs_data, rs_busy} !== '0) begin
        nfail++;
        $display("FAIL sweep_zero addr=%0d data=%h busy=%b want 0", a, rs_data, rs_busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    int na, nb;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int n = 0; n < 10; n++) tick();
    nvec++;
    if (ready !== 1'b0) begin
      nfail++;
      $display("FAIL mid_not_ready got %b want 0", ready);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_ready(na, nb);
    nvec++;
    if (na != 32 || nb != 16) begin
      nfail++;
      $display("FAIL mid_restart got %0d/%0d want 32/16", na, nb);
    end
  endtask

  task automatic test_collision();
    clr_in();
    drv_wr(0, 5'd5, 32'h1111, 1'b0);
    drv_wr(1, 5'd5, 32'h2222, 1'b0);
    drv_rd(5'd5, 5'd5);
    #1;
    nvec++;
    if (rs_data[63:32] !== (BYP ? 32'h2222 : 32'h0)) begin
      nfail++;
      $display("FAIL collision_same_cycle got %h want %h", rs_data[63:32], BYP ? 32'h2222 : 32'h0);
    end
    tick();
    clr_in();
    #1;
    nvec++;
    if (rs_data[31:0] !== 32'h2222) begin
      nfail++;
      $display("FAIL collision_x5 got %h want 00002222", rs_data[31:0]);
    end
    drv_wr(0, 5'd6, 32'h6666, 1'b0);
    drv_wr(1, 5'd31, 32'h3131, 1'b0);
    tick();
    clr_in();
    drv_rd(5'd6, 5'd31);
    #1;
    nvec++;
    if (rs_data !== {32'h3131, 32'h6666}) begin
      nfail++;
      $display("FAIL dual_distinct got %h want 0000313100006666", rs_data);
    end
  endtask

  task automatic test_x0_range();
    clr_in();
    drv_wr(1, 5'd0, 32'hDEAD, 1'b0);
    bset_en = 1'b1; bset_addr = 5'd0;
    tick();
    clr_in();
    drv_rd(5'd0, 5'd0);
    #1;
    nvec++;
    if ({rs_data, rs_busy} !== '0) begin
      nfail++;
      $display("FAIL x0_hardwired data=%h busy=%b want 0", rs_data, rs_busy);
    end
    b_wr_en = 2'b11;
    b_wr_addr = {5'd15, 5'd20};
    b_wr_data = {32'h1515, 32'h2020};
    b_bset_en = 1'b1; b_bset_addr = 5'd20;
    tick();
    clr_in();
    b_rs_addr = {5'd15, 5'd20};
    #1;
    nvec++;
    if (b_rs_data !== {32'h1515, 32'h0} || b_rs_busy !== 2'b00) begin
      nfail++;
      $display("FAIL out_of_range data=%h busy=%b want 0000151500000000/00", b_rs_data, b_rs_busy);
    end
  endtask

  task automatic test_bypass();
    clr_in();
    drv_wr(0, 5'd7, 32'h0001, 1'b0);
    tick();
    clr_in();
    drv_wr(0, 5'd7, 32'hABCD, 1'b0);
    drv_rd(5'd7, 5'd7);
    #1;
    nvec++;
    if (rs_data !== (BYP ? {32'hABCD, 32'hABCD} : {32'h0001, 32'h0001})) begin
      nfail++;
      $display("FAIL bypass_same_cycle got %h want %h", rs_data,
               BYP ? {32'hABCD, 32'hABCD} : {32'h0001, 32'h0001});
    end
    tick();
    clr_in();
    #1;
    nvec++;
    if (rs_data !== {32'hABCD, 32'hABCD}) begin
      nfail++;
      $display("FAIL bypass_next_cycle got %h want 0000abcd0000abcd", rs_data);
    end
  endtask

  task automatic test_scoreboard();
    clr_in();
    bset_en = 1'b1; bset_addr = 5'd3;
    drv_rd(5'd3, 5'd4);
    #1;
    nvec++;
    if (rs_busy !== 2'b00) begin
      nfail++;
      $display("FAIL busy_registered got %b want 00", rs_busy);
    end
    tick();
    clr_in();
    #1;
    nvec++;
    if (rs_busy !== 2'b01) begin
      nfail++;
      $display("FAIL busy_set_x3 got %b want 01", rs_busy);
    end
    drv_wr(0, 5'd3, 32'h33, 1'b1);
    bset_en = 1'b1; bset_addr = 5'd3;
    tick();
    clr_in();
    #1;
    nvec++;
    if (rs_busy !== 2'b01 || rs_data[31:0] !== 32'h33) begin
      nfail++;
      $display("FAIL set_beats_clear busy=%b data=%h want 01/00000033", rs_busy, rs_data[31:0]);
    end
    drv_wr(1, 5'd3, 32'h34, 1'b1);
    #1;
    nvec++;
    if (rs_busy[0] !== !BYP) begin
      nfail++;
      $display("FAIL clear_same_cycle got %b want %b", rs_busy[0], !BYP);
    end
    tick();
    clr_in();
    #1;
    nvec++;
    if (rs_busy !== 2'b00 || rs_data[31:0] !== 32'h34) begin
      nfail++;
      $display("FAIL clear_x3 busy=%b data=%h want 00/00000034", rs_busy, rs_data[31:0]);
    end
    bset_en = 1'b1; bset_addr = 5'd4;
    tick();
    clr_in();
    drv_wr(0, 5'd4, 32'h44, 1'b0);
    tick();
    clr_in();
    #1;
    nvec++;
    if (rs_busy !== 2'b10) begin
      nfail++;
      $display("FAIL write_without_clr got %b want 10", rs_busy);
    end
  endtask

  task automatic test_reset_busy();
    int na, nb;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_ready(na, nb);
    drv_rd(5'd4, 5'd4);
    #1;
    nvec++;
    if (na != 32 || rs_busy !== 2'b00 || rs_data !== '0) begin
      nfail++;
      $display("FAIL reset_clears_busy ready_at=%0d busy=%b data=%h want 32/00/0", na, rs_busy, rs_data);
    end
  endtask

  initial begin
    reset = 1'b1;
    clr_in();
    rs_addr = '0;
    b_rs_addr = '0;
    test_reset();
    test_reset_mid();
    test_collision();
    test_x0_range();
    test_bypass();
    test_scoreboard();
    test_reset_busy();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
